// File: rtl/fm_audio_decimator.sv
// fm_audio_decimator: integrate-and-dump boxcar low-pass and decimate-by-DECIM
// for the FM demodulator's frequency samples, AXI-Stream on both sides.
module fm_audio_decimator #(
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int LOG2_DECIM = 3
) (
    input  logic                                s00_axis_aclk,
    input  logic                                s00_axis_aresetn,
    input  logic                                s00_axis_tvalid,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic                                s00_axis_tlast,
    input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
    output logic                                s00_axis_tready,
    input  logic                                m00_axis_tready,
    output logic                                m00_axis_tvalid,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
    output logic                                m00_axis_tlast,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb
);

    localparam int DECIM = 2 ** LOG2_DECIM;
    localparam int AW = 16 + LOG2_DECIM;
    localparam logic [LOG2_DECIM-1:0] LAST_CNT = LOG2_DECIM'(DECIM - 1);

    logic [LOG2_DECIM-1:0] cnt;
    logic signed [AW-1:0]  acc;
    logic signed [AW-1:0]  sum;
    logic                  lst;
    logic                  win_end;
    logic                  accept;
    logic                  done;
    logic [15:0]           avg;
    logic                  unused_ok;

    assign sum = acc + {{LOG2_DECIM{s00_axis_tdata[15]}}, s00_axis_tdata[15:0]};

    // Dropping the low LOG2_DECIM bits is the floor-dividing arithmetic shift.
    assign avg = sum[AW-1:LOG2_DECIM];

    assign win_end = (cnt == LAST_CNT);
    assign s00_axis_tready = ~(win_end & m00_axis_tvalid & ~m00_axis_tready);
    assign accept = s00_axis_tvalid & s00_axis_tready;
    assign done = accept & win_end;

    assign unused_ok = ^{s00_axis_tdata, s00_axis_tstrb};

    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_aresetn) begin
            cnt             <= '0;
            acc             <= '0;
            lst             <= 1'b0;
            m00_axis_tvalid <= 1'b0;
            m00_axis_tdata  <= '0;
            m00_axis_tlast  <= 1'b0;
            m00_axis_tstrb  <= '0;
        end else begin
            if (m00_axis_tvalid && m00_axis_tready && !done) begin
                m00_axis_tvalid <= 1'b0;
            end
            if (accept) begin
                if (win_end) begin
                    m00_axis_tdata  <= C_M00_AXIS_TDATA_WIDTH'(avg);
                    m00_axis_tlast  <= lst | s00_axis_tlast;
                    m00_axis_tvalid <= 1'b1;
                    m00_axis_tstrb  <= '1;
                    acc             <= '0;
                    lst             <= 1'b0;
                    cnt             <= '0;
                end else begin
                    acc <= sum;
                    lst <= lst | s00_axis_tlast;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fm_audio_decimator.sv
// tb_fm_audio_decimator: scoreboard bench with a window-averaging reference
// model, directed corner cases and randomized traffic with backpressure.
module tb_fm_audio_decimator;

    localparam int LOG2 = 3;
    localparam int DECIM = 2 ** LOG2;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_tvalid = 1'b0;
    logic [31:0] s_tdata = '0;
    logic        s_tlast = 1'b0;
    logic [3:0]  s_tstrb = '0;
    logic        s_tready;
    logic        m_tready = 1'b0;
    logic        m_tvalid;
    logic [31:0] m_tdata;
    logic        m_tlast;
    logic [3:0]  m_tstrb;

    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    logic rst_d = 1'b0;
    bit   rdy_mode = 0;

    exp_t q[$];
    int   acc_m = 0;
    int   cnt_m = 0;
    bit   lst_m = 0;
    int   done_cyc = -1;
    exp_t lat_exp;

    fm_audio_decimator #(
        .C_S00_AXIS_TDATA_WIDTH(32),
        .C_M00_AXIS_TDATA_WIDTH(32),
        .LOG2_DECIM(LOG2)
    ) dut (
        .s00_axis_aclk(clk),
        .s00_axis_aresetn(rst),
        .s00_axis_tvalid(s_tvalid),
        .s00_axis_tdata(s_tdata),
        .s00_axis_tlast(s_tlast),
        .s00_axis_tstrb(s_tstrb),
        .s00_axis_tready(s_tready),
        .m00_axis_tready(m_tready),
        .m00_axis_tvalid(m_tvalid),
        .m00_axis_tdata(m_tdata),
        .m00_axis_tlast(m_tlast),
        .m00_axis_tstrb(m_tstrb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_d <= rst;
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    endtask

    task automatic model_reset();
        acc_m = 0;
        cnt_m = 0;
        lst_m = 0;
        q.delete();
    endtask

    task automatic model_accept(input logic [15:0] d, input logic l);
        int   qv;
        exp_t e;
        acc_m += int'($signed(d));
        lst_m |= l;
        cnt_m++;
        if (cnt_m == DECIM) begin
            qv = acc_m / DECIM;
            if ((acc_m % DECIM) != 0 && acc_m < 0) qv -= 1;
            e.data = {16'h0, qv[15:0]};
            e.last = lst_m;
            q.push_back(e);
            lat_exp  = e;
            done_cyc = cyc + 1;
            acc_m = 0;
            cnt_m = 0;
            lst_m = 0;
        end
    endtask

    task automatic send_beat(input logic [15:0] d, input logic l, output int w);
        bit   ok;
        logic exp_rdy;
        s_tvalid = 1'b1;
        s_tdata  = {16'($urandom()), d};
        s_tstrb  = 4'($urandom());
        s_tlast  = l;
        ok = 0;
        w  = 0;
        while (!ok && w < 200) begin
            @(negedge clk);
            #1;
            exp_rdy = !(cnt_m == DECIM - 1 && q.size() > 0 && !m_tready);
            check("s_tready", {31'h0, s_tready}, {31'h0, exp_rdy});
            if (s_tready) begin
                model_accept(d, l);
                ok = 1;
            end else begin
                w++;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            n_chk++;
            $display("FAIL send_timeout: beat not accepted after %0d cycles, expected acceptance", w);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send(input logic [15:0] d, input logic l);
        int w;
        send_beat(d, l, w);
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Output monitor: scoreboard pop, stall stability, reset state.
    initial begin
        logic        pv = 0;
        logic        pr = 0;
        logic [31:0] pd = 0;
        logic        pl = 0;
        logic [3:0]  ps = 0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rst_d) begin
                check("rst_tvalid", {31'h0, m_tvalid}, 32'h0);
                check("rst_tdata", m_tdata, 32'h0);
                check("rst_tlast", {31'h0, m_tlast}, 32'h0);
                check("rst_tstrb", {28'h0, m_tstrb}, 32'h0);
                pv = 0;
            end else begin
                if (pv && !pr) begin
                    check("stall_tvalid", {31'h0, m_tvalid}, 32'h1);
                    check("stall_tdata", m_tdata, pd);
                    check("stall_tlast", {31'h0, m_tlast}, {31'h0, pl});
                    check("stall_tstrb", {28'h0, m_tstrb}, {28'h0, ps});
                end
                if (m_tvalid && m_tready) begin
                    if (q.size() == 0) begin
                        n_chk++;
                        $display("FAIL extra_beat: got 0x%08h, expected no output", m_tdata);
                    end else begin
                        e = q.pop_front();
                        check("out_tdata", m_tdata, e.data);
                        check("out_tlast", {31'h0, m_tlast}, {31'h0, e.last});
                        check("out_tstrb", {28'h0, m_tstrb}, 32'hF);
                    end
                end
                pv = m_tvalid;
                pr = m_tready;
                pd = m_tdata;
                pl = m_tlast;
                ps = m_tstrb;
            end
        end
    end

    // A completed window must show up right after its accepting edge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (cyc == done_cyc) begin
                check("lat_tvalid", {31'h0, m_tvalid}, 32'h1);
                check("lat_tdata", m_tdata, lat_exp.data);
                check("lat_tlast", {31'h0, m_tlast}, {31'h0, lat_exp.last});
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode) m_tready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int          w;
        logic [15:0] v;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        m_tready = 1'b1;
        idle(1);

        for (int i = 0; i < 8; i++) send(16'd100, 1'b0);
        idle(3);
        for (int i = 1; i <= 8; i++) send(16'(i), 1'b0);
        for (int i = 1; i <= 8; i++) send(16'(-i), 1'b0);
        for (int i = 0; i < 8; i++) send(16'h7FFF, 1'b0);
        for (int i = 0; i < 8; i++) send(16'h8000, 1'b0);
        idle(3);

        for (int i = 0; i < 8; i++) send(16'(20 + i), 1'b0);
        m_tready = 1'b0;
        for (int i = 0; i < 7; i++) send(16'd50, 1'b0);
        fork
            send_beat(16'd60, 1'b0, w);
            begin
                repeat (4) @(posedge clk);
                #1;
                m_tready = 1'b1;
                @(posedge clk);
                #1;
                m_tready = 1'b0;
            end
        join
        check("stall_cycles", w, 4);
        idle(3);
        m_tready = 1'b1;
        idle(2);

        for (int i = 0; i < 24; i++) send(16'($urandom()), (i == 10));
        idle(3);

        for (int i = 0; i < 5; i++) send(16'd1000, 1'b0);
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) send(16'd8, 1'b0);
        idle(3);

        rdy_mode = 1;
        for (int i = 0; i < 320; i++) begin
            case ($urandom_range(0, 9))
                0: v = 16'h7FFF;
                1: v = 16'h8000;
                default: v = 16'($urandom());
            endcase
            send(v, ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rdy_mode = 0;
        m_tready = 1'b1;
        for (int i = 0; i < 50 && q.size() != 0; i++) idle(1);
        idle(2);
        check("queue_empty", q.size(), 0);
        check("final_tvalid", {31'h0, m_tvalid}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fm_audio_decimator.md
Name: fm_audio_decimator

Overview:
- Sits directly downstream of the FM phase-difference demodulator.
- Consumes its AXI-Stream output: a signed 16-bit instantaneous-frequency sample in tdata[15:0] at the RF sample rate.
- Low-pass filters with a DECIM-tap boxcar (integrate-and-dump), then decimates by DECIM. The result feeds the audio path at the reduced rate.
- Full AXI-Stream handshaking on both sides, with backpressure propagated upstream.

Parameters:
- C_S00_AXIS_TDATA_WIDTH, 32, input stream width; only [15:0] used.
- C_M00_AXIS_TDATA_WIDTH, 32, output stream width.
- LOG2_DECIM, 3, log2 of the decimation factor. Legal range 1..8.
- DECIM, 2**LOG2_DECIM, decimation factor and boxcar length. Derived; not overridden independently.

Ports:
- s00_axis_aclk  in  1  sole clock.
- s00_axis_aresetn  in  1  synchronous, active-high reset. The name is kept for bus consistency; polarity is high-true.
- s00_axis_tvalid  in  1  input sample valid.
- s00_axis_tdata  in  C_S00_AXIS_TDATA_WIDTH  [15:0] is the signed frequency sample; upper bits ignored.
- s00_axis_tlast  in  1  packet marker.
- s00_axis_tstrb  in  C_S00_AXIS_TDATA_WIDTH/8  ignored.
- s00_axis_tready  out  1  input accept.
- m00_axis_tready  in  1  downstream accept.
- m00_axis_tvalid  out  1  output valid.
- m00_axis_tdata  out  C_M00_AXIS_TDATA_WIDTH  [15:0] is the signed averaged sample; [31:16] is 0.
- m00_axis_tlast  out  1  packet marker for this window.
- m00_axis_tstrb  out  C_M00_AXIS_TDATA_WIDTH/8  all ones whenever tvalid is 1.

Behaviour:
- Reset (s00_axis_aresetn=1 at a clock edge):
  - m00_axis_tvalid=0, m00_axis_tdata=0, m00_axis_tlast=0, m00_axis_tstrb=0.
  - Sample counter=0, accumulator=0, tlast-sticky=0.
  - Reset has priority over every other event.
  - Reset mid-window discards the partial window; the next output uses DECIM fresh samples.
- Accept: an input beat is accepted when s00_axis_tvalid && s00_axis_tready.
- State: counter cnt in 0..DECIM-1; accumulator acc, signed, 16+LOG2_DECIM bits; sticky flag lst.
- Accepted beat with cnt < DECIM-1:
  - acc <= acc + sext(tdata[15:0]).
  - lst <= lst | tlast.
  - cnt <= cnt+1.
- Accepted beat with cnt == DECIM-1 (window complete):
  - m00_axis_tdata[15:0] <= (acc + sext(tdata[15:0])) >>> LOG2_DECIM. This is an arithmetic shift, so the result is floor division; no rounding is applied.
  - Bits above [15:0] of m00_axis_tdata are 0.
  - m00_axis_tlast <= lst | tlast.
  - m00_axis_tvalid <= 1; m00_axis_tstrb <= all ones.
  - acc <= 0, lst <= 0, cnt <= 0.
- Latency: the output is valid on the cycle after the DECIM-th sample is accepted.
- Overflow: the accumulator width guarantees no overflow, and the shifted result always fits in 16 signed bits.
- Output register: when m00_axis_tvalid && m00_axis_tready and no new window completes this cycle, m00_axis_tvalid <= 0. tdata and tlast hold until overwritten.
- Simultaneous drain and window completion: the register is reloaded and m00_axis_tvalid stays 1. No bubble and no lost sample.
- Backpressure: s00_axis_tready = ~((cnt == DECIM-1) && m00_axis_tvalid && ~m00_axis_tready). This is combinational.
  - Samples 0..DECIM-2 of a window are always accepted, even while the output is stalled.
  - Only the window-completing sample waits.
- Output stability: while m00_axis_tvalid=1 and m00_axis_tready=0, m00_axis_tdata, m00_axis_tlast and m00_axis_tstrb do not change.
- Input tlast: does not terminate a window early. Packet alignment is the upstream's responsibility.
- Throughput: one input sample per clock when unstalled.

Test Plan:
- Defaults (DECIM=8), tready=1, eight samples of 100 → one output beat tdata=0x00000064, tlast=0, tstrb=0xF, one cycle after the 8th accept.
- Samples 1..8 → 0x00000004 (36>>>3). Samples -1..-8 → 0x0000FFFB (-36 floor/8 = -5).
- Eight samples of 0x7FFF → 0x00007FFF. Eight samples of 0x8000 → 0x00008000. Confirms no accumulator overflow.
- Backpressure: m00_axis_tready=0 after the first output, continuous input.
  - The next 7 samples are accepted; s00_axis_tready drops with the 8th presented.
  - Output data holds stable.
  - Raise m00_axis_tready for one cycle → first beat drains, 8th sample accepted the same cycle, m00_axis_tvalid stays 1 with the new average.
- tlast=1 on the 3rd sample of window 2 only → window 1 output tlast=0, window 2 tlast=1, window 3 tlast=0.
- Reset asserted one cycle after 5 samples of 1000 are accepted, then eight samples of 8 → single output 0x00000008. No beat reflects the discarded samples, and tvalid=0 throughout the reset.
